// File: rtl/pong_pkg.sv
// Shared constants and types for the pong datapath: screen geometry, coordinate
// widths, colours and the rectangle plotter state encoding.
package pong_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam int unsigned X_W      = 9;
    localparam int unsigned Y_W      = 8;
    localparam int unsigned COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StDraw,
        StFinish
    } plot_state_e;

endpackage

// File: rtl/raster_counter.sv
// Row-major column/row counter bounded by a width/height pair. Exposes the
// next-state position so a caller can register outputs in step with it.
module raster_counter
    import pong_pkg::*;
#(
    parameter int unsigned ColW = X_W,
    parameter int unsigned RowW = Y_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            step_i,
    input  logic [ColW-1:0] width_i,
    input  logic [RowW-1:0] height_i,
    output logic [ColW-1:0] cx_next_o,
    output logic [RowW-1:0] cy_next_o,
    output logic            last_o
);

    logic [ColW-1:0] cx_q, cx_d;
    logic [RowW-1:0] cy_q, cy_d;
    logic            row_end;

    always_comb begin
        row_end = (cx_q == width_i - ColW'(1));
        last_o  = row_end && (cy_q == height_i - RowW'(1));
        cx_d    = cx_q;
        cy_d    = cy_q;
        if (clear_i) begin
            cx_d = '0;
            cy_d = '0;
        end else if (step_i) begin
            if (row_end) begin
                cx_d = '0;
                cy_d = cy_q + RowW'(1);
            end else begin
                cx_d = cx_q + ColW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx_next_o = cx_d;
    assign cy_next_o = cy_d;

endmodule

// File: rtl/rect_plotter.sv
// Rectangle raster engine: one latched request becomes one registered pixel
// write per clock, row-major, with off-screen pixels suppressed but still timed.
module rect_plotter
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_W = pong_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = pong_pkg::SCREEN_H
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      width,
    input  logic [Y_W-1:0]      height,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    localparam logic [X_W:0] XLim = SCREEN_W[X_W:0];
    localparam logic [Y_W:0] YLim = SCREEN_H[Y_W:0];

    plot_state_e state_q, state_d;

    logic [X_W-1:0]      x0_q, w_q, x0_s, cx_next;
    logic [Y_W-1:0]      y0_q, h_q, y0_s, cy_next;
    logic [COLOUR_W-1:0] col_q, col_s;

    logic                busy_q, busy_d, done_q, done_d, plot_q, plot_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;

    logic           accept, step, emit, last;
    logic [X_W:0]   sum_x;
    logic [Y_W:0]   sum_y;
    logic           on_screen;

    raster_counter #(
        .ColW (X_W),
        .RowW (Y_W)
    ) u_raster_counter (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (accept),
        .step_i    (step),
        .width_i   (w_q),
        .height_i  (h_q),
        .cx_next_o (cx_next),
        .cy_next_o (cy_next),
        .last_o    (last)
    );

    // Pixel 0 is registered on the accepting edge, so it must come straight
    // from the request inputs rather than the not-yet-loaded latches.
    always_comb begin
        x0_s      = (state_q == StIdle) ? x0 : x0_q;
        y0_s      = (state_q == StIdle) ? y0 : y0_q;
        col_s     = (state_q == StIdle) ? colour_in : col_q;
        sum_x     = {1'b0, x0_s} + {1'b0, cx_next};
        sum_y     = {1'b0, y0_s} + {1'b0, cy_next};
        on_screen = (sum_x < XLim) && (sum_y < YLim);
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        step     = 1'b0;
        emit     = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        plot_d   = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept = 1'b1;
                    busy_d = 1'b1;
                    if (width == '0 || height == '0) begin
                        state_d = StFinish;
                    end else begin
                        state_d = StDraw;
                        emit    = 1'b1;
                    end
                end
            end
            StDraw: begin
                busy_d = 1'b1;
                if (last) begin
                    state_d = StFinish;
                    done_d  = 1'b1;
                end else begin
                    step = 1'b1;
                    emit = 1'b1;
                end
            end
            StFinish: begin
                // A zero-size request arrives here without done raised yet and
                // spends one extra busy cycle before pulsing it.
                if (done_q) begin
                    state_d = StIdle;
                end else begin
                    busy_d = 1'b1;
                    done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (emit) begin
            x_d      = sum_x[X_W-1:0];
            y_d      = sum_y[Y_W-1:0];
            colour_d = col_s;
            plot_d   = on_screen;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            plot_q   <= plot_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            if (accept) begin
                x0_q  <= x0;
                y0_q  <= y0;
                w_q   <= width;
                h_q   <= height;
                col_q <= colour_in;
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign plot   = plot_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Self-checking bench for rect_plotter: directed and random rectangles compared
// cycle by cycle against a row-major pixel model of the request.
module tb_rect_plotter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] x0, width;
    logic [7:0] y0, height;
    logic [2:0] colour_in;
    logic       busy, done, plot;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;

    int checks   = 0;
    int failures = 0;

    rect_plotter dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .width     (width),
        .height    (height),
        .colour_in (colour_in),
        .busy      (busy),
        .done      (done),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble_inputs();
        x0        = 9'($urandom);
        y0        = 8'($urandom);
        width     = 9'($urandom);
        height    = 8'($urandom);
        colour_in = 3'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first
    // idle cycle after the request, start already low.
    task automatic run_rect(input int ux0, input int uy0, input int uw, input int uh,
                            input int uc, input bit hold_start, output int nplots,
                            output int first_x, output int first_y,
                            output int last_x, output int last_y);
        int exp_plots;
        int sx, sy;
        bit vis;
        nplots    = 0;
        exp_plots = 0;
        first_x   = -1;
        first_y   = -1;
        last_x    = -1;
        last_y    = -1;
        x0        = ux0[8:0];
        y0        = uy0[7:0];
        width     = uw[8:0];
        height    = uh[7:0];
        colour_in = uc[2:0];
        start     = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        scramble_inputs();
        if (uw == 0 || uh == 0) begin
            @(negedge clk);
            check_eq("zero_busy", busy, 1);
            check_eq("zero_done", done, 0);
            check_eq("zero_plot", plot, 0);
        end else begin
            for (int k = 0; k < uw * uh; k++) begin
                sx  = ux0 + (k % uw);
                sy  = uy0 + (k / uw);
                vis = (sx < 160) && (sy < 120);
                if (vis) exp_plots++;
                @(negedge clk);
                check_eq("pix_busy", busy, 1);
                check_eq("pix_done", done, 0);
                check_eq("pix_plot", plot, vis);
                if (plot) begin
                    nplots++;
                    if (first_x < 0) begin
                        first_x = x;
                        first_y = y;
                    end
                    last_x = x;
                    last_y = y;
                end
                if (vis) begin
                    check_eq("pix_x", x, sx);
                    check_eq("pix_y", y, sy);
                    check_eq("pix_colour", colour, uc);
                end
                if (hold_start) scramble_inputs();
            end
        end
        @(negedge clk);
        check_eq("fin_done", done, 1);
        check_eq("fin_busy", busy, 1);
        check_eq("fin_plot", plot, 0);
        @(negedge clk);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_done", done, 0);
        check_eq("idle_plot", plot, 0);
        start = 1'b0;
        check_eq("plot_count", nplots, exp_plots);
    endtask

    initial begin
        int n, fx, fy, lx, ly;
        reset     = 1'b1;
        start     = 1'b0;
        x0        = '0;
        y0        = '0;
        width     = '0;
        height    = '0;
        colour_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_plot", plot, 0);
        check_eq("rst_x", x, 0);
        check_eq("rst_y", y, 0);
        check_eq("rst_colour", colour, 0);
        reset = 1'b0;
        @(negedge clk);

        run_rect(0, 0, 160, 120, 0, 1'b0, n, fx, fy, lx, ly);
        check_eq("clear_plots", n, 19200);
        check_eq("clear_first", fx * 256 + fy, 0);
        check_eq("clear_last", lx * 256 + ly, 159 * 256 + 119);
        @(negedge clk);

        // start held high throughout the request must not trigger a second one
        run_rect(4, 50, 2, 16, 7, 1'b1, n, fx, fy, lx, ly);
        check_eq("paddle_plots", n, 32);
        check_eq("paddle_first", fx * 256 + fy, 4 * 256 + 50);
        check_eq("paddle_last", lx * 256 + ly, 5 * 256 + 65);
        repeat (3) begin
            @(negedge clk);
            check_eq("paddle_no_retrigger", busy, 0);
        end

        run_rect(158, 118, 4, 4, 5, 1'b0, n, fx, fy, lx, ly);
        check_eq("clip_plots", n, 4);
        check_eq("clip_first", fx * 256 + fy, 158 * 256 + 118);
        check_eq("clip_last", lx * 256 + ly, 159 * 256 + 119);
        @(negedge clk);

        run_rect(10, 10, 0, 5, 3, 1'b0, n, fx, fy, lx, ly);
        check_eq("zero_plots", n, 0);
        @(negedge clk);

        // Reset while pixel 10 of a 4x4 rectangle is on the outputs
        x0        = 9'd1;
        y0        = 8'd1;
        width     = 9'd4;
        height    = 8'd4;
        colour_in = 3'd6;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(negedge clk);
        check_eq("mid_plot", plot, 1);
        check_eq("mid_x", x, 3);
        check_eq("mid_y", y, 3);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_plot", plot, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_eq("post_rst_done", done, 0);
            check_eq("post_rst_plot", plot, 0);
        end
        run_rect(20, 30, 3, 2, 1, 1'b0, n, fx, fy, lx, ly);
        check_eq("post_rst_first", fx * 256 + fy, 20 * 256 + 30);

        // Back-to-back: second start is presented in the very first idle cycle
        run_rect(0, 0, 5, 1, 2, 1'b0, n, fx, fy, lx, ly);
        run_rect(100, 100, 3, 3, 4, 1'b0, n, fx, fy, lx, ly);
        check_eq("b2b_first", fx * 256 + fy, 100 * 256 + 100);

        for (int i = 0; i < 40; i++) begin
            int rx, ry, rw, rh;
            rx = (i % 4 == 0) ? $urandom_range(511, 150) : $urandom_range(159, 0);
            ry = (i % 5 == 0) ? $urandom_range(255, 110) : $urandom_range(119, 0);
            rw = $urandom_range(12, 0);
            rh = $urandom_range(8, 0);
            run_rect(rx, ry, rw, rh, $urandom_range(7, 0), 1'($urandom), n, fx, fy, lx, ly);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
